hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Producer-side companion to the ID-stage forwarding unit in the 5-stage MIPS pipeline. It tracks the destination register, write-enable and load flag of every in-flight instruction in EX and MEM, presents that state as the `*E` / `*M` inputs the forwarding unit consumes, and raises stall/flush whenever forwarding alone cannot satisfy an ID-stage operand. It also counts hazard stall cycles for performance monitoring.

## Interface
- `CNT_W`, 32, width of the hazard-stall counter.
- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `valid_d`  in  1  ID holds a real instruction (0 = bubble).
- `rs_addr_d`, `rt_addr_d`  in  5  ID source register addresses.
- `uses_rs_d`, `uses_rt_d`  in  1  the instruction reads rs / rt.
- `is_branch_d`  in  1  beq/bne/jr; operands are consumed in ID.
- `reg_write_d`  in  1  ID instruction writes a register.
- `write_reg_addr_d`  in  5  ID destination register, already resolved from rt/rd/31.
- `mem_to_reg_d`  in  1  ID instruction is a load.
- `ext_stall`  in  1  whole-pipeline freeze, e.g. from memory wait.
- `reg_writeE`, `write_reg_addrE`, `mem_to_regE`  out  1/5/1  EX-slot state.
- `reg_writeM`, `write_reg_addrM`, `mem_to_regM`  out  1/5/1  MEM-slot state.
- `stall_f`, `stall_d`  out  1  hold the PC and the IF/ID register.
- `flush_e`  out  1  insert a bubble into ID/EX.
- `stall_count`  out  `CNT_W`  saturating count of hazard-stall cycles.

## Operation
- Each slot (E, M) holds `{reg_write, addr, mem_to_reg}`. A slot is "live for reg r" when `reg_write=1`, `addr!=0` and `addr==r`.
- The `match` terms below are evaluated for the sources used in ID: `rs_addr_d` if `uses_rs_d`, `rt_addr_d` if `uses_rt_d`, each gated by `valid_d`.
- **Load-use hazard:** E is a load (`mem_to_regE=1`) and E is live for a used source.
- **Branch hazard:** `is_branch_d=1` and either:
  - E is live for a used source (ALU result not yet available), or
  - M is a load and M is live for a used source.
- Branch dependence on a non-load in M is resolved by forwarding, so it does not stall.
- `hz = load_use | branch_hz`.
- `stall_f = stall_d = flush_e = hz & ~ext_stall`.
- Register $0 never causes a hazard.
- Writeback-stage dependences never stall. The register file writes in the first half-cycle and reads in the second.

## Timing
- Hazard outputs are combinational from slot registers and ID inputs, with no added latency.
- Slot update at each rising edge, in priority order:
  - `reset`: both slots cleared to all zero.
  - `ext_stall=1`: both slots hold.
  - `hz=1`: M takes E; E is cleared to a bubble.
  - otherwise: M takes E; E takes the ID fields ANDed with `valid_d`.
- `stall_count` behaviour:
  - cleared by `reset`;
  - increments on cycles where `hz & ~ext_stall`;
  - saturates at all-ones and does not wrap.
- Reset values: all `*E` / `*M` outputs are 0, `stall_f`/`stall_d`/`flush_e` are 0 provided ID inputs are 0, and `stall_count` is 0.
- Reset asserted mid-stall: slots clear on that edge, so any stall caused by slot state is gone the next cycle.
- Stall durations:
  - load followed by a dependent ALU op: 1 cycle;
  - ALU op followed by a dependent branch: 1 cycle;
  - load followed by a dependent branch: 2 cycles (first with the load in E, then with the load in M).
- `ext_stall` simultaneous with a hazard: no flush, no count; the hazard re-evaluates after release.

## Test plan
- **Load-use:** `lw $8` enters E, then ID = `add` using rs=8 → `stall_d=flush_e=1` for exactly 1 cycle. Next cycle E=bubble, `write_reg_addrM=8`, no stall. `stall_count=1`.
- **Load then branch:** `lw $9`, then `beq` with rt=9 → stall for 2 consecutive cycles, `stall_count=2`. On the third cycle the stall is 0 and the load sits in WB.
- **ALU then branch, with and without gap:**
  - `add $10`, then `bne` reading rs=10 → 1-cycle stall.
  - `add $10`, one independent instruction, then `bne` rs=10 → no stall (MEM forward).
- **$0 and unused operands:**
  - `lw $0`, then `add` reading $0 → no stall.
  - `lw $5`, then `j` with `uses_rs_d=uses_rt_d=0` and rs=5 → no stall.
- **ext_stall:** hold `ext_stall=1` for 3 cycles during a load-use hazard → slots unchanged, `flush_e=0`, count unchanged. On release, the 1-cycle stall occurs.
- **Reset and saturation:**
  - assert `reset` mid-stall → all outputs return to 0 next cycle.
  - with `CNT_W=2`, produce 5 hazard cycles → `stall_count=3`.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// ID-stage operand/destination bundle plus the EX/MEM slot state and hazard
// controls the scoreboard returns to the pipeline and the forwarding unit.
interface hazard_scoreboard_if #(
  parameter int CNT_W = 32
);
  logic             valid_d;
  logic [4:0]       rs_addr_d;
  logic [4:0]       rt_addr_d;
  logic             uses_rs_d;
  logic             uses_rt_d;
  logic             is_branch_d;
  logic             reg_write_d;
  logic [4:0]       write_reg_addr_d;
  logic             mem_to_reg_d;
  logic             ext_stall;

  logic             reg_writeE;
  logic [4:0]       write_reg_addrE;
  logic             mem_to_regE;
  logic             reg_writeM;
  logic [4:0]       write_reg_addrM;
  logic             mem_to_regM;
  logic             stall_f;
  logic             stall_d;
  logic             flush_e;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output valid_d, rs_addr_d, rt_addr_d, uses_rs_d, uses_rt_d, is_branch_d,
           reg_write_d, write_reg_addr_d, mem_to_reg_d, ext_stall,
    input  reg_writeE, write_reg_addrE, mem_to_regE,
           reg_writeM, write_reg_addrM, mem_to_regM,
           stall_f, stall_d, flush_e, stall_count
  );

  modport slave (
    input  valid_d, rs_addr_d, rt_addr_d, uses_rs_d, uses_rt_d, is_branch_d,
           reg_write_d, write_reg_addr_d, mem_to_reg_d, ext_stall,
    output reg_writeE, write_reg_addrE, mem_to_regE,
           reg_writeM, write_reg_addrM, mem_to_regM,
           stall_f, stall_d, flush_e, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks destination/write/load state of the EX and MEM instructions and raises
// stall/flush when forwarding cannot satisfy an ID operand; counts stall cycles.
module hazard_scoreboard #(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  hazard_scoreboard_if.slave sb
);

  // valid_d qualifies the ID fields: a bubble never matches a slot and never
  // enters E; while stall_d is high ID re-presents the same instruction.
  logic             e_rw_q, e_rw_d;
  logic [4:0]       e_wa_q, e_wa_d;
  logic             e_m2r_q, e_m2r_d;
  logic             m_rw_q, m_rw_d;
  logic [4:0]       m_wa_q, m_wa_d;
  logic             m_m2r_q, m_m2r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic rs_used, rt_used;
  logic e_hit, m_hit;
  logic load_use, branch_hz, hz, stall;

  always_comb begin
    rs_used = sb.valid_d & sb.uses_rs_d;
    rt_used = sb.valid_d & sb.uses_rt_d;
    e_hit = e_rw_q && (e_wa_q != 5'd0) &&
            ((rs_used && (e_wa_q == sb.rs_addr_d)) ||
             (rt_used && (e_wa_q == sb.rt_addr_d)));
    m_hit = m_rw_q && (m_wa_q != 5'd0) &&
            ((rs_used && (m_wa_q == sb.rs_addr_d)) ||
             (rt_used && (m_wa_q == sb.rt_addr_d)));
    load_use  = e_m2r_q & e_hit;
    // A non-load in MEM is forwarded to the ID comparator, so only loads stall.
    branch_hz = sb.is_branch_d & (e_hit | (m_m2r_q & m_hit));
    hz        = load_use | branch_hz;
    stall     = hz & ~sb.ext_stall;
  end

  always_comb begin
    e_rw_d  = e_rw_q;
    e_wa_d  = e_wa_q;
    e_m2r_d = e_m2r_q;
    m_rw_d  = m_rw_q;
    m_wa_d  = m_wa_q;
    m_m2r_d = m_m2r_q;
    if (!sb.ext_stall) begin
      m_rw_d  = e_rw_q;
      m_wa_d  = e_wa_q;
      m_m2r_d = e_m2r_q;
      if (hz) begin
        e_rw_d  = 1'b0;
        e_wa_d  = 5'd0;
        e_m2r_d = 1'b0;
      end else begin
        e_rw_d  = sb.reg_write_d & sb.valid_d;
        e_wa_d  = sb.write_reg_addr_d & {5{sb.valid_d}};
        e_m2r_d = sb.mem_to_reg_d & sb.valid_d;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_rw_q  <= 1'b0;
      e_wa_q  <= 5'd0;
      e_m2r_q <= 1'b0;
      m_rw_q  <= 1'b0;
      m_wa_q  <= 5'd0;
      m_m2r_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      e_rw_q  <= e_rw_d;
      e_wa_q  <= e_wa_d;
      e_m2r_q <= e_m2r_d;
      m_rw_q  <= m_rw_d;
      m_wa_q  <= m_wa_d;
      m_m2r_q <= m_m2r_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sb.reg_writeE      = e_rw_q;
  assign sb.write_reg_addrE = e_wa_q;
  assign sb.mem_to_regE     = e_m2r_q;
  assign sb.reg_writeM      = m_rw_q;
  assign sb.write_reg_addrM = m_wa_q;
  assign sb.mem_to_regM     = m_m2r_q;
  assign sb.stall_f         = stall;
  assign sb.stall_d         = stall;
  assign sb.flush_e         = stall;
  assign sb.stall_count     = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Table-driven check of hazard_scoreboard: per-cycle ID inputs with hand-derived
// slot/stall/count expectations; a CNT_W=2 copy checks counter saturation.
module tb_hazard_scoreboard;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       br;
    logic       rw;
    logic [4:0] wa;
    logic       m2r;
  } id_t;

  typedef struct packed {
    logic       rw;
    logic [4:0] wa;
    logic       m2r;
  } slot_t;

  typedef struct {
    string name;
    logic  rst;
    logic  ext;
    id_t   id;
    logic  hz;
    slot_t e;
    slot_t m;
    int    cnt;
  } vec_t;

  localparam int EW = 51;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];
  logic [EW-1:0] exp_q[$];

  hazard_scoreboard_if #(.CNT_W(32)) sb();
  hazard_scoreboard_if #(.CNT_W(2))  sb2();

  hazard_scoreboard #(.CNT_W(32)) dut  (.clk(clk), .reset(reset), .sb(sb));
  hazard_scoreboard #(.CNT_W(2))  dut2 (.clk(clk), .reset(reset), .sb(sb2));

  assign sb2.valid_d          = sb.valid_d;
  assign sb2.rs_addr_d        = sb.rs_addr_d;
  assign sb2.rt_addr_d        = sb.rt_addr_d;
  assign sb2.uses_rs_d        = sb.uses_rs_d;
  assign sb2.uses_rt_d        = sb.uses_rt_d;
  assign sb2.is_branch_d      = sb.is_branch_d;
  assign sb2.reg_write_d      = sb.reg_write_d;
  assign sb2.write_reg_addr_d = sb.write_reg_addr_d;
  assign sb2.mem_to_reg_d     = sb.mem_to_reg_d;
  assign sb2.ext_stall        = sb.ext_stall;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  function automatic id_t idle();
    id_t t = '0;
    return t;
  endfunction

  function automatic id_t lw(input logic [4:0] rd, input logic [4:0] base);
    id_t t = '0;
    t.v = 1'b1; t.rs = base; t.urs = 1'b1; t.rw = 1'b1; t.wa = rd; t.m2r = 1'b1;
    return t;
  endfunction

  function automatic id_t alu(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    id_t t = '0;
    t.v = 1'b1; t.rs = a; t.rt = b; t.urs = 1'b1; t.urt = 1'b1; t.rw = 1'b1; t.wa = rd;
    return t;
  endfunction

  function automatic id_t brn(input logic [4:0] a, input logic [4:0] b);
    id_t t = '0;
    t.v = 1'b1; t.rs = a; t.rt = b; t.urs = 1'b1; t.urt = 1'b1; t.br = 1'b1;
    return t;
  endfunction

  function automatic id_t jmp(input logic [4:0] a);
    id_t t = '0;
    t.v = 1'b1; t.rs = a; t.rt = a;
    return t;
  endfunction

  function automatic slot_t sl(input logic rw, input logic [4:0] wa, input logic m2r);
    slot_t s;
    s.rw = rw; s.wa = wa; s.m2r = m2r;
    return s;
  endfunction

  function automatic logic [1:0] sat2(input int c);
    logic [31:0] cc;
    cc = c;
    return (c > 3) ? 2'd3 : cc[1:0];
  endfunction

  task automatic add(input string name, input logic rst, input logic ext, input id_t id,
                     input logic hz, input slot_t e, input slot_t m, input int cnt);
    vec_t r;
    r.name = name; r.rst = rst; r.ext = ext; r.id = id;
    r.hz = hz; r.e = e; r.m = m; r.cnt = cnt;
    vecs.push_back(r);
  endtask

  // driver
  task automatic drive(input vec_t r);
    reset               = r.rst;
    sb.ext_stall        = r.ext;
    sb.valid_d          = r.id.v;
    sb.rs_addr_d        = r.id.rs;
    sb.rt_addr_d        = r.id.rt;
    sb.uses_rs_d        = r.id.urs;
    sb.uses_rt_d        = r.id.urt;
    sb.is_branch_d      = r.id.br;
    sb.reg_write_d      = r.id.rw;
    sb.write_reg_addr_d = r.id.wa;
    sb.mem_to_reg_d     = r.id.m2r;
  endtask

  // scoreboard
  task automatic check(input string name);
    logic [EW-1:0] exp_v, act_v;
    act_v = {sb.stall_f, sb.stall_d, sb.flush_e,
             sb.reg_writeE, sb.write_reg_addrE, sb.mem_to_regE,
             sb.reg_writeM, sb.write_reg_addrM, sb.mem_to_regM,
             sb.stall_count, sb2.stall_count};
    exp_v = exp_q.pop_front();
    n_checks++;
    if (act_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got sf/sd/fe=%b%b%b E=%b M=%b cnt=%0d cnt2=%0d, expected sf/sd/fe=%b%b%b E=%b M=%b cnt=%0d cnt2=%0d",
               name, act_v[50], act_v[49], act_v[48], act_v[47:41], act_v[40:34],
               act_v[33:2], act_v[1:0], exp_v[50], exp_v[49], exp_v[48],
               exp_v[47:41], exp_v[40:34], exp_v[33:2], exp_v[1:0]);
    end
  endtask

  initial begin
    slot_t z, l8, l9, a10, a11, a12, l0, a13, l5;
    id_t   t;
    z   = sl(0, 0, 0);
    l8  = sl(1, 8, 1);
    l9  = sl(1, 9, 1);
    a10 = sl(1, 10, 0);
    a11 = sl(1, 11, 0);
    a12 = sl(1, 12, 0);
    l0  = sl(1, 0, 1);
    a13 = sl(1, 13, 0);
    l5  = sl(1, 5, 1);

    add("reset_state",   0, 0, idle(),           0, z,   z,   0);
    add("lu_lw8",        0, 0, lw(8, 1),         0, z,   z,   0);
    add("lu_stall",      0, 0, alu(11, 8, 2),    1, l8,  z,   0);
    add("lu_release",    0, 0, alu(11, 8, 2),    0, z,   l8,  1);
    add("lu_add_in_e",   0, 0, idle(),           0, a11, z,   1);
    add("lu_drain",      0, 0, idle(),           0, z,   a11, 1);
    add("lb_lw9",        0, 0, lw(9, 1),         0, z,   z,   1);
    add("lb_stall1",     0, 0, brn(3, 9),        1, l9,  z,   1);
    add("lb_stall2",     0, 0, brn(3, 9),        1, z,   l9,  2);
    add("lb_release",    0, 0, brn(3, 9),        0, z,   z,   3);
    add("ab_add10",      0, 0, alu(10, 1, 2),    0, z,   z,   3);
    add("ab_stall",      0, 0, brn(10, 0),       1, a10, z,   3);
    add("ab_release",    0, 0, brn(10, 0),       0, z,   a10, 4);
    add("gap_add10",     0, 0, alu(10, 1, 2),    0, z,   z,   4);
    add("gap_indep",     0, 0, alu(12, 4, 5),    0, a10, z,   4);
    add("gap_bne_fwd",   0, 0, brn(10, 0),       0, a12, a10, 4);
    add("gap_drain",     0, 0, idle(),           0, z,   a12, 4);
    add("r0_lw0",        0, 0, lw(0, 1),         0, z,   z,   4);
    add("r0_add_r0",     0, 0, alu(13, 0, 0),    0, l0,  z,   4);
    add("un_lw5",        0, 0, lw(5, 1),         0, a13, l0,  4);
    add("un_jump",       0, 0, jmp(5),           0, l5,  a13, 4);
    t = brn(5, 5); t.v = 1'b0; t.rw = 1'b1; t.wa = 5'd7;
    add("bubble_gated",  0, 0, t,                0, z,   l5,  4);
    add("bubble_e_zero", 0, 0, idle(),           0, z,   z,   4);
    add("ex_lw8",        0, 0, lw(8, 1),         0, z,   z,   4);
    add("ex_hold1",      0, 1, alu(11, 8, 2),    0, l8,  z,   4);
    add("ex_hold2",      0, 1, alu(11, 8, 2),    0, l8,  z,   4);
    add("ex_hold3",      0, 1, alu(11, 8, 2),    0, l8,  z,   4);
    add("ex_stall",      0, 0, alu(11, 8, 2),    1, l8,  z,   4);
    add("ex_release",    0, 0, alu(11, 8, 2),    0, z,   l8,  5);
    add("ex_add_in_e",   0, 0, idle(),           0, a11, z,   5);
    add("ex_drain",      0, 0, idle(),           0, z,   a11, 5);
    add("rs_lw8",        0, 0, lw(8, 1),         0, z,   z,   5);
    add("rs_mid_stall",  1, 0, alu(11, 8, 2),    1, l8,  z,   5);
    add("rs_cleared",    0, 0, alu(11, 8, 2),    0, z,   z,   0);
    add("rs_add_in_e",   0, 0, idle(),           0, a11, z,   0);

    reset = 1'b1;
    drive('{name: "init", rst: 1'b1, ext: 1'b0, id: idle(), hz: 1'b0, e: z, m: z, cnt: 0});
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      exp_q.push_back({{3{vecs[i].hz}}, vecs[i].e, vecs[i].m,
                       32'(vecs[i].cnt), sat2(vecs[i].cnt)});
      #2;
      check(vecs[i].name);
    end

    @(negedge clk);
    reset = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
